// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between the instruction memory port and decode.
// Buffers up to DEPTH {pc, instruction} pairs, keeps at most one memory request
// outstanding, and on a redirect abandons any in-flight request by draining it.
module instr_prefetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic [ADDR_WIDTH-1:0]      i_jump_addr,
  input  logic                       i_instr_ready,
  input  logic [DATA_WIDTH-1:0]      i_instr_data,
  output logic                       o_inst_rd_en,
  output logic [ADDR_WIDTH-1:0]      o_inst_addr,
  output logic                       o_if_valid,
  output logic [DATA_WIDTH-1:0]      o_if_inst,
  output logic [ADDR_WIDTH-1:0]      o_if_pc,
  input  logic                       i_id_ready,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  start_q;
  logic                  pending_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] drain_addr_q;
  logic [ADDR_WIDTH-1:0] jump_pc;

  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_inst [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_d;
  logic [CNT_W-1:0]      count_d;

  logic                  if_valid_q;
  logic [DATA_WIDTH-1:0] if_inst_q;
  logic [ADDR_WIDTH-1:0] if_pc_q;
  logic [DATA_WIDTH-1:0] head_inst_d;
  logic [ADDR_WIDTH-1:0] head_pc_d;
  logic                  head_hit;

  logic                  completion;
  logic                  queue_full;
  logic                  push;
  logic                  pop;

  // The two low address bits of a redirect are not meaningful for word fetch.
  logic unused_jump_bits;
  assign unused_jump_bits = ^i_jump_addr[1:0];

  assign jump_pc    = {i_jump_addr[ADDR_WIDTH-1:2], 2'b00};
  assign completion = o_inst_rd_en & i_instr_ready;
  assign queue_full = (count_q == CNT_W'(DEPTH));
  // Data is only kept in RUN; a redirect in the same cycle makes it stale.
  assign push       = (state_q == RUN) & completion & ~i_flush;
  // A redirect cancels any pop, since the whole queue is discarded anyway.
  assign pop        = if_valid_q & i_id_ready & ~i_flush;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter DRAIN when a redirect abandons a request that is still waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (i_flush && pending_q && !i_instr_ready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_instr_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Memory request outputs; a pending request is held regardless of redirect or occupancy.
  always_comb begin
    o_inst_rd_en = 1'b0;
    o_inst_addr  = fetch_pc_q;
    case (state_q)
      RUN: begin
        o_inst_rd_en = pending_q | (start_q & ~queue_full & ~i_flush);
        o_inst_addr  = fetch_pc_q;
      end
      DRAIN: begin
        o_inst_rd_en = 1'b1;
        o_inst_addr  = drain_addr_q;
      end
      default: begin
        o_inst_rd_en = 1'b0;
        o_inst_addr  = fetch_pc_q;
      end
    endcase
  end

  // Start flag holds off fetching until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b1;
    end
  end

  // Remember whether a request was issued but not yet completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= o_inst_rd_en & ~i_instr_ready;
    end
  end

  // Fetch PC follows redirects, otherwise advances by one word per kept completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else if (i_flush) begin
      fetch_pc_q <= jump_pc;
    end else if (push) begin
      fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
    end
  end

  // Capture the abandoned address so it stays on the bus while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_addr_q <= RESET_PC;
    end else if (state_q == RUN && state_d == DRAIN) begin
      drain_addr_q <= fetch_pc_q;
    end
  end

  // Queue storage writes; contents need no reset because occupancy guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= fetch_pc_q;
      mem_inst[wr_ptr_q] <= i_instr_data;
    end
  end

  // Next pointers and occupancy; a redirect empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next head entry; bypass the write when the incoming word becomes the new head.
  always_comb begin
    head_hit    = push && (wr_ptr_q == rd_ptr_d);
    head_pc_d   = mem_pc[rd_ptr_d];
    head_inst_d = mem_inst[rd_ptr_d];
    if (head_hit) begin
      head_pc_d   = fetch_pc_q;
      head_inst_d = i_instr_data;
    end
  end

  // Registered head toward decode; contents only refresh when an entry will be present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      if_valid_q <= (count_d != '0);
      if (count_d != '0) begin
        if_pc_q   <= head_pc_d;
        if_inst_q <= head_inst_d;
      end
    end
  end

  assign o_if_valid = if_valid_q;
  assign o_if_pc    = if_pc_q;
  assign o_if_inst  = if_inst_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Testbench for instr_prefetch_queue: directed scenarios plus randomized traffic,
// checked by a queue-based reference model and a decoupled head monitor.
module tb_instr_prefetch_queue;

  localparam int          DW       = 32;
  localparam int          AW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_flush = 1'b0;
  logic [AW-1:0] i_jump_addr = '0;
  logic          i_instr_ready = 1'b0;
  logic [DW-1:0] i_instr_data;
  logic          o_inst_rd_en;
  logic [AW-1:0] o_inst_addr;
  logic          o_if_valid;
  logic [DW-1:0] o_if_inst;
  logic [AW-1:0] o_if_pc;
  logic          i_id_ready = 1'b0;
  logic [2:0]    o_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state, expressed in terms of the fetch stream
  int          occ = 0;
  bit          started = 1'b0;
  bit          pending = 1'b0;
  bit          drain = 1'b0;
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_drain_addr = RESET_PC;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_flush(i_flush),
    .i_jump_addr(i_jump_addr),
    .i_instr_ready(i_instr_ready),
    .i_instr_data(i_instr_data),
    .o_inst_rd_en(o_inst_rd_en),
    .o_inst_addr(o_inst_addr),
    .o_if_valid(o_if_valid),
    .o_if_inst(o_if_inst),
    .o_if_pc(o_if_pc),
    .i_id_ready(i_id_ready),
    .o_count(o_count)
  );

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  assign i_instr_data = mem_word(o_inst_addr);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic [31:0] ja, input logic rdy, input logic idr);
    i_flush       = fl;
    i_jump_addr   = ja;
    i_instr_ready = rdy;
    i_id_ready    = idr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_en"}, 64'(o_inst_rd_en), 64'(0));
    checkOutput({tag, "_addr"},  64'(o_inst_addr),  64'(RESET_PC));
    checkOutput({tag, "_valid"}, 64'(o_if_valid),   64'(0));
    checkOutput({tag, "_inst"},  64'(o_if_inst),    64'(0));
    checkOutput({tag, "_pc"},    64'(o_if_pc),      64'(0));
    checkOutput({tag, "_count"}, 64'(o_count),      64'(0));
  endtask

  // Reference model: checks the request side and predicts which words enter the queue
  initial begin : model
    bit          exp_rd;
    bit          comp;
    bit          pop;
    bit          push;
    logic [31:0] exp_addr;
    entry_t      e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        occ          = 0;
        started      = 1'b0;
        pending      = 1'b0;
        drain        = 1'b0;
        m_fetch_pc   = RESET_PC;
        m_drain_addr = RESET_PC;
      end else begin
        exp_rd   = drain || pending || (started && occ < DEPTH && !i_flush);
        exp_addr = drain ? m_drain_addr : m_fetch_pc;
        checkOutput("rd_en", 64'(o_inst_rd_en), 64'(exp_rd));
        if (exp_rd) checkOutput("req_addr", 64'(o_inst_addr), 64'(exp_addr));
        comp = exp_rd && i_instr_ready;
        pop  = (occ != 0) && i_id_ready && !i_flush;
        push = 1'b0;
        if (drain) begin
          if (comp) drain = 1'b0;
          if (i_flush) m_fetch_pc = {i_jump_addr[31:2], 2'b00};
        end else if (i_flush) begin
          if (pending && !comp) begin
            drain        = 1'b1;
            m_drain_addr = m_fetch_pc;
          end
          m_fetch_pc = {i_jump_addr[31:2], 2'b00};
        end else if (comp) begin
          e.pc   = m_fetch_pc;
          e.inst = mem_word(m_fetch_pc);
          exp_q.push_back(e);
          push       = 1'b1;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (i_flush) begin
          exp_q.delete();
          occ = 0;
        end else begin
          occ = occ + int'(push) - int'(pop);
        end
        pending = exp_rd && !i_instr_ready;
        started = 1'b1;
      end
    end
  end

  // Monitor: compares the presented head against the scoreboard and retires it on pop
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("count", 64'(o_count), 64'(occ));
        checkOutput("if_valid", 64'(o_if_valid), 64'(occ != 0));
        if (o_if_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL head_present: actual valid with no expected entry at %0t", $time);
          end else begin
            checkOutput("if_pc", 64'(o_if_pc), 64'(exp_q[0].pc));
            checkOutput("if_inst", 64'(o_if_inst), 64'(exp_q[0].inst));
            if (i_id_ready && !i_flush) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stimulus
    int ready_pct;
    #3;
    checkResetValues("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-wait memory, decode always ready
    repeat (20) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // Decode stalls until the queue fills, then a single pop
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("full_count", 64'(o_count), 64'(DEPTH));
    checkOutput("full_rd_en", 64'(o_inst_rd_en), 64'(0));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("after_pop_rd_en", 64'(o_inst_rd_en), 64'(1));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("refill_count", 64'(o_count), 64'(DEPTH));

    // Two redirects while draining an abandoned request
    applyStimulus(1'b0, 32'h0,  1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0,  1'b0, 1'b1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0,  1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0,  1'b1, 1'b1);
    checkOutput("post_drain_addr", 64'(o_inst_addr), 64'(32'h80));
    checkOutput("post_drain_rd_en", 64'(o_inst_rd_en), 64'(1));
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect to an unaligned target with three entries held and nothing pending
    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("three_count", 64'(o_count), 64'(3));
    applyStimulus(1'b1, 32'h203, 1'b1, 1'b0);
    checkOutput("flush_count", 64'(o_count), 64'(0));
    checkOutput("flush_valid", 64'(o_if_valid), 64'(0));
    checkOutput("flush_addr", 64'(o_inst_addr), 64'(32'h200));
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of fetching with two entries held
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("pre_reset_count", 64'(o_count), 64'(2));
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Memory ready every third cycle, redirect to 0x100 while 0x8 is outstanding
    for (int i = 0; i < 21; i++) begin
      applyStimulus((i == 8), 32'h100, (i > 0) && (i % 3 == 0), 1'b1);
      if (i == 7) checkOutput("pending_addr", 64'(o_inst_addr), 64'(32'h8));
      if (i == 9) checkOutput("redirect_addr", 64'(o_inst_addr), 64'(32'h100));
    end

    // Randomized traffic with varying memory latency, decode stalls and redirects
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 3)
        0:       ready_pct = 100;
        1:       ready_pct = 70;
        default: ready_pct = 33;
      endcase
      applyStimulus(($urandom_range(0, 19) == 0), $urandom(),
                    ($urandom_range(0, 99) < ready_pct), ($urandom_range(0, 3) != 0));
    end

    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
